// File: rtl/nios_core_ocimem_access_sequencer_if.sv
// RAM-side bus between the OCI access sequencer and the single-port debug RAM.
// The sequencer is the master; the RAM (or its model) is the slave.
interface nios_core_ocimem_access_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/nios_core_ocimem_access_sequencer.sv
// OCI debug RAM access sequencer: turns JTAG memory strobes into queued RAM
// accesses, arbitrates them against the CPU debug-monitor port, and reports
// read data and status back to the debug host.
module nios_core_ocimem_access_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int QDEPTH     = 2,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [37:0]         jdo_i,
  input  logic                take_action_ocimem_a_i,
  input  logic                take_action_ocimem_b_i,
  input  logic                take_no_action_ocimem_a_i,
  input  logic                debugack_i,
  input  logic                cpu_read_i,
  input  logic                cpu_write_i,
  input  logic [ADDR_W-1:0]   cpu_address_i,
  input  logic [31:0]         cpu_writedata_i,
  output logic                cpu_waitrequest_o,
  output logic [31:0]         cpu_readdata_o,
  nios_core_ocimem_access_sequencer_if.master mem,
  output logic [31:0]         MonDReg_o,
  output logic                monitor_ready_o,
  output logic                monitor_error_o
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TMO_V     = TW'(TIMEOUT);
  localparam logic [SW-1:0] STARVE_V  = SW'(STARVE_MAX);
  localparam logic [2:0]    QDEPTH_V  = 3'(QDEPTH);
  localparam logic [1:0]    QLAST_V   = 2'(QDEPTH - 1);
  localparam logic [31:0]   TMO_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

  // Circular-buffer pointer advance, wrapping at the configured depth.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == QLAST_V) ? 2'd0 : p + 2'd1;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]          count_q, count_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                owner_dbg_q, owner_dbg_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_wait_q, cpu_wait_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d, mon_q, mon_d;
  logic                ready_q, ready_d, err_q, err_d;

  // Pending debug commands; in-flight command lives in the mem_* registers.
  logic                q_we_q   [4];
  logic [ADDR_W-1:0]   q_addr_q [4];
  logic [31:0]         q_data_q [4];

  logic                enq_s, enq_we_s, load_addr_s, clr_err_s;
  logic                enq_ok_s, ovf_s, pop_s, tmo_err_s, cpu_req_s, dbg_win_s;
  logic [ADDR_W-1:0]   enq_addr_s, jdo_addr_s;
  logic [31:0]         enq_data_s;
  logic [TW-1:0]       tmo_inc_s;
  logic                jdo_unused_s;

  assign jdo_addr_s   = jdo_i[ADDR_W+16:17];
  assign enq_data_s   = jdo_i[34:3];
  assign jdo_unused_s = ^{jdo_i[37:35], jdo_i[2:0]};
  assign cpu_req_s    = cpu_read_i | cpu_write_i;
  assign dbg_win_s    = (count_q != 3'd0) &&
                        (debugack_i || !cpu_req_s || (starve_q == STARVE_V));

  // Decode the JTAG strobes (a > b > no_action) into one enqueue request.
  always_comb begin
    enq_s       = 1'b0;
    enq_we_s    = 1'b0;
    load_addr_s = 1'b0;
    clr_err_s   = 1'b0;
    enq_addr_s  = addr_q;
    if (take_action_ocimem_a_i) begin
      load_addr_s = 1'b1;
      clr_err_s   = 1'b1;
      enq_addr_s  = jdo_addr_s;
      enq_s       = jdo_i[34];
    end else if (take_action_ocimem_b_i) begin
      enq_s    = 1'b1;
      enq_we_s = 1'b1;
    end else if (take_no_action_ocimem_a_i) begin
      enq_s = 1'b1;
    end else begin
      enq_s = 1'b0;
    end
  end

  // Arbitration, access FSM, queue bookkeeping and host status next-state.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    owner_dbg_d = owner_dbg_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    mon_d       = mon_q;
    pop_s       = 1'b0;
    tmo_err_s   = 1'b0;
    tmo_inc_s   = tmo_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (dbg_win_s) begin
          pop_s       = 1'b1;
          state_d     = S_ACCESS;
          owner_dbg_d = 1'b1;
          starve_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = q_we_q[rd_ptr_q];
          mem_addr_d  = q_addr_q[rd_ptr_q];
          mem_wdata_d = q_data_q[rd_ptr_q];
        end else if (cpu_req_s) begin
          state_d     = S_ACCESS;
          owner_dbg_d = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_write_i;
          mem_addr_d  = cpu_address_i;
          mem_wdata_d = cpu_writedata_i;
          if (count_q != 3'd0) begin
            starve_d = starve_q + SW'(1);
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (mem.mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q && owner_dbg_q) begin
            mon_d = mem.mem_rdata;
          end else if (!mem_we_q) begin
            cpu_rdata_d = mem.mem_rdata;
          end else begin
            mon_d = mon_q;
          end
        end else if (tmo_inc_s == TMO_V) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (owner_dbg_q) begin
            tmo_err_s = 1'b1;
          end else begin
            cpu_rdata_d = TMO_RDATA;
          end
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A full queue still accepts a command if the head leaves this cycle.
    enq_ok_s = enq_s && ((count_q < QDEPTH_V) || pop_s);
    ovf_s    = enq_s && !enq_ok_s;
    wr_ptr_d = enq_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({enq_ok_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // ocimem_a loads the address without advancing it; b/no_action advance.
    if (load_addr_s && !ovf_s) begin
      addr_d = jdo_addr_s;
    end else if (enq_ok_s) begin
      addr_d = addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end

    // Error is sticky; setting beats the ocimem_a clear.
    if (ovf_s || tmo_err_s) begin
      err_d = 1'b1;
    end else if (clr_err_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    cpu_wait_d = !((state_d == S_DONE) && !owner_dbg_d);
    ready_d    = (count_d == 3'd0) && !((state_d != S_IDLE) && owner_dbg_d);
  end

  // State, queue and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      starve_q    <= '0;
      tmo_q       <= '0;
      owner_dbg_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      cpu_wait_q  <= 1'b1;
      cpu_rdata_q <= 32'h0000_0000;
      mon_q       <= 32'h0000_0000;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        q_we_q[i]   <= 1'b0;
        q_addr_q[i] <= '0;
        q_data_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      owner_dbg_q <= owner_dbg_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_wait_q  <= cpu_wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      mon_q       <= mon_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      if (enq_ok_s) begin
        q_we_q[wr_ptr_q]   <= enq_we_s;
        q_addr_q[wr_ptr_q] <= enq_addr_s;
        q_data_q[wr_ptr_q] <= enq_data_s;
      end
    end
  end

  assign mem.mem_req        = mem_req_q;
  assign mem.mem_we         = mem_we_q;
  assign mem.mem_addr       = mem_addr_q;
  assign mem.mem_wdata      = mem_wdata_q;
  assign cpu_waitrequest_o  = cpu_wait_q;
  assign cpu_readdata_o     = cpu_rdata_q;
  assign MonDReg_o          = mon_q;
  assign monitor_ready_o    = ready_q;
  assign monitor_error_o    = err_q;

endmodule
